// File: rtl/fft_pkg.sv
// Shared sizes, FSM state encoding and helpers for the 32-point FFT address controller.
// FFT_CTRL_UNLOAD_EN adds the UNLOAD state (bit-reversed result unload).
package fft_pkg;

  localparam int N_PTS      = 32;
  localparam int ADDR_W     = 5;
  localparam int J_W        = 4;
  localparam int STAGE_W    = 3;
  localparam int NUM_STAGES = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FLUSH  = 3'd2,
`ifdef FFT_CTRL_UNLOAD_EN
    S_UNLOAD = 3'd3,
`endif
    S_DONE   = 3'd4
  } fft_state_t;

  function automatic logic [ADDR_W-1:0] bit_rev5(input logic [ADDR_W-1:0] x);
    logic [ADDR_W-1:0] r;
    for (int k = 0; k < ADDR_W; k++) r[k] = x[ADDR_W-1-k];
    return r;
  endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Bus between the FFT controller and its memory/butterfly datapath.
// FFT_CTRL_UNLOAD_EN enables the out_valid/out_addr unload traffic.
interface fft_ctrl_if;
  import fft_pkg::*;

  // Strobes carry no ready: rd_en, wr_en and out_valid each qualify their
  // address fields in the same cycle, and the datapath must accept every one.
  // stall is the only back-pressure; while high no strobe is raised.
  logic                start;
  logic                stall;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [J_W-1:0]      tw_addr;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr_a;
  logic [ADDR_W-1:0]   wr_addr_b;
  logic [STAGE_W-1:0]  stage;
  logic                busy;
  logic                done;
  logic                out_valid;
  logic [ADDR_W-1:0]   out_addr;
  fft_state_t          fsm_state;

  modport master (
    input  start, stall,
    output rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b,
           stage, busy, done, out_valid, out_addr, fsm_state
  );

  modport slave (
    output start, stall,
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b,
           stage, busy, done, out_valid, out_addr, fsm_state
  );

endinterface

// File: rtl/fft_addr_rot.sv
// Butterfly operand addresses and twiddle index for stage i, butterfly j.
// No configuration macros.
module fft_addr_rot
  import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] i,
    input  logic [J_W-1:0]     j,
    output logic [ADDR_W-1:0]  a,
    output logic [ADDR_W-1:0]  b,
    output logic [J_W-1:0]     tw
);

    logic [2*ADDR_W-1:0] dbl_a;
    logic [2*ADDR_W-1:0] dbl_b;
    logic [J_W-1:0]      mask;

    // Shifting a doubled copy left by i leaves the 5-bit rotation in the top half.
    always_comb begin
        dbl_a = {2{j, 1'b0}} << i;
        dbl_b = {2{j, 1'b1}} << i;
        a     = dbl_a[2*ADDR_W-1:ADDR_W];
        b     = dbl_b[2*ADDR_W-1:ADDR_W];
        case (i)
            3'd0:    mask = 4'h0;
            3'd1:    mask = 4'h8;
            3'd2:    mask = 4'hC;
            3'd3:    mask = 4'hE;
            default: mask = 4'hF;
        endcase
        tw = j & mask;
    end

endmodule

// File: rtl/fft_ctrl.sv
// Radix-2 32-point FFT sequencer: issues butterfly reads, tracks write-back latency.
// FFT_CTRL_UNLOAD_EN adds a 32-cycle bit-reversed unload before DONE.
module fft_ctrl
  import fft_pkg::*;
#(
    parameter int BF_LAT = 3
) (
    input logic       clk,
    input logic       rst_n,
    fft_ctrl_if.master bus
);

    localparam logic [2:0]         FLUSH_LAST = 3'(BF_LAT - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [J_W-1:0]     J_LAST     = '1;

    fft_state_t          state, state_nxt;
    logic [STAGE_W-1:0]  stage_q;
    logic [J_W-1:0]      j_q;
    logic [2:0]          flush_q;
    logic [BF_LAT-1:0]   pipe_v;
    logic [ADDR_W-1:0]   pipe_a [BF_LAT];
    logic [ADDR_W-1:0]   pipe_b [BF_LAT];
    logic [ADDR_W-1:0]   addr_a, addr_b;
    logic [J_W-1:0]      tw;
    logic                rd_issue, wr_issue;
`ifdef FFT_CTRL_UNLOAD_EN
    logic [ADDR_W-1:0]   unload_q;
`endif

    fft_addr_rot u_rot (.i(stage_q), .j(j_q), .a(addr_a), .b(addr_b), .tw(tw));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (j_q == J_LAST) state_nxt = S_FLUSH;
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    if (stage_q < LAST_STAGE) state_nxt = S_RUN;
`ifdef FFT_CTRL_UNLOAD_EN
                    else                      state_nxt = S_UNLOAD;
`else
                    else                      state_nxt = S_DONE;
`endif
                end
            end
`ifdef FFT_CTRL_UNLOAD_EN
            S_UNLOAD: if (unload_q == ADDR_W'(N_PTS - 1)) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rd_issue = (state == S_RUN) && !bus.stall;
    assign wr_issue = pipe_v[BF_LAT-1] && !bus.stall;

    // A stall freezes everything at once, so every update sits under !stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            flush_q <= '0;
            pipe_v  <= '0;
            for (int s = 0; s < BF_LAT; s++) begin
                pipe_a[s] <= '0;
                pipe_b[s] <= '0;
            end
`ifdef FFT_CTRL_UNLOAD_EN
            unload_q <= '0;
`endif
        end else if (!bus.stall) begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    stage_q <= '0;
                    j_q     <= '0;
                    flush_q <= '0;
                end
                S_RUN: j_q <= j_q + J_W'(1);
                S_FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        flush_q <= '0;
                        if (stage_q < LAST_STAGE) stage_q <= stage_q + STAGE_W'(1);
                    end else begin
                        flush_q <= flush_q + 3'd1;
                    end
                end
`ifdef FFT_CTRL_UNLOAD_EN
                S_UNLOAD: unload_q <= unload_q + ADDR_W'(1);
`endif
                S_DONE: stage_q <= '0;
                default: ;
            endcase
            pipe_v[0] <= rd_issue;
            pipe_a[0] <= addr_a;
            pipe_b[0] <= addr_b;
            for (int s = 1; s < BF_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_a[s] <= pipe_a[s-1];
                pipe_b[s] <= pipe_b[s-1];
            end
        end
    end

    assign bus.rd_en     = rd_issue;
    assign bus.rd_addr_a = rd_issue ? addr_a : '0;
    assign bus.rd_addr_b = rd_issue ? addr_b : '0;
    assign bus.tw_addr   = rd_issue ? tw : '0;
    assign bus.wr_en     = wr_issue;
    assign bus.wr_addr_a = wr_issue ? pipe_a[BF_LAT-1] : '0;
    assign bus.wr_addr_b = wr_issue ? pipe_b[BF_LAT-1] : '0;
    assign bus.stage     = stage_q;
    assign bus.done      = (state == S_DONE) && !bus.stall;
    assign bus.fsm_state = state;
`ifdef FFT_CTRL_UNLOAD_EN
    assign bus.busy      = (state == S_RUN) || (state == S_FLUSH) || (state == S_UNLOAD);
    assign bus.out_valid = (state == S_UNLOAD) && !bus.stall;
    assign bus.out_addr  = bus.out_valid ? bit_rev5(unload_q) : '0;
`else
    assign bus.busy      = (state == S_RUN) || (state == S_FLUSH);
    assign bus.out_valid = 1'b0;
    assign bus.out_addr  = '0;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: timing of reads/writes/done, stall, mid-run reset.
// Honours FFT_CTRL_UNLOAD_EN when defined for the build.
module tb_fft_ctrl;
  import fft_pkg::*;

  localparam int BF_LAT = 3;
  localparam int W = 10;
`ifdef FFT_CTRL_UNLOAD_EN
  localparam int DONE_CYC = 128;
  localparam int EXP_OV   = 32;
`else
  localparam int DONE_CYC = 96;
  localparam int EXP_OV   = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  fft_ctrl_if bus ();

  fft_ctrl #(.BF_LAT(BF_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int t0 = 0;
  bit mon_en = 1'b0;

  int rd_cnt, wr_cnt, done_cnt, done_cyc, first_rd, first_wr, ov_cnt, unst, m_i, m_j;
  logic [W-1:0] exp_q[$];
  int ts_q[$];
  logic [3:0] tw_mask [5] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF};

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [4:0] rot5(input logic [4:0] x, input int n);
    logic [4:0] r;
    r = x;
    for (int s = 0; s < n; s++) r = {r[3:0], r[4]};
    return r;
  endfunction

  function automatic logic [4:0] brev(input int k);
    logic [4:0] x, r;
    x = k[4:0];
    for (int s = 0; s < 5; s++) r[s] = x[4-s];
    return r;
  endfunction

  task automatic clear_model();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_rd = -1; first_wr = -1;
    ov_cnt = 0; unst = 0; m_i = 0; m_j = 0;
    exp_q.delete();
    ts_q.delete();
  endtask

  // Scoreboard: reads against a rotate model, writes against queued reads.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      int rel;
      logic [3:0] jj;
      logic [W-1:0] e;
      rel = cyc_cnt - t0;
      if (!bus.stall) unst++;
      if (bus.stall) check("stall_quiet", {29'd0, bus.rd_en, bus.wr_en, bus.out_valid}, 32'd0);
      if (bus.rd_en) begin
        jj = m_j[3:0];
        check("rd_addr_a", bus.rd_addr_a, rot5({jj, 1'b0}, m_i));
        check("rd_addr_b", bus.rd_addr_b, rot5({jj, 1'b1}, m_i));
        check("tw_addr", bus.tw_addr, jj & tw_mask[m_i]);
        exp_q.push_back({bus.rd_addr_a, bus.rd_addr_b});
        ts_q.push_back(unst);
        if (first_rd < 0) first_rd = rel;
        rd_cnt++;
        m_j++;
        if (m_j == 16) begin m_j = 0; m_i++; end
      end
      if (bus.wr_en) begin
        if (first_wr < 0) first_wr = rel;
        wr_cnt++;
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", {bus.wr_addr_a, bus.wr_addr_b}, e);
          check("wr_latency", unst - ts_q.pop_front(), BF_LAT);
        end
      end
      if (bus.out_valid) begin
        check("out_addr", bus.out_addr, brev(ov_cnt));
        ov_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = rel;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc_cnt - t0 < n) step();
  endtask

  task automatic run_start();
    clear_model();
    t0 = cyc_cnt;
    bus.start = 1'b1;
    mon_en = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (done_cyc < 0 && n < 300) begin step(); n++; end
    check({tag, "_done_cyc"}, done_cyc, exp_cyc);
    repeat (3) step();
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_rd_cnt"}, rd_cnt, 80);
    check({tag, "_wr_cnt"}, wr_cnt, 80);
    check({tag, "_ov_cnt"}, ov_cnt, EXP_OV);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, bus.fsm_state, S_IDLE);
    check({tag, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    clear_model();
    repeat (3) step();
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr_b", bus.rd_addr_b, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stage", bus.stage, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_state", bus.fsm_state, S_IDLE);
    rst_n = 1'b1;
    repeat (2) step();

    // Run 1: unstalled, with hand-computed butterfly addresses.
    run_start();
    check("r1_busy_c1", bus.busy, 1);
    wait_to(2);
    check("i0j1_a", bus.rd_addr_a, 2);
    check("i0j1_b", bus.rd_addr_b, 3);
    check("i0j1_tw", bus.tw_addr, 0);
    wait_to(17);
    check("c17_rd_en", bus.rd_en, 0);
    check("c17_state", bus.fsm_state, S_FLUSH);
    check("c17_busy", bus.busy, 1);
    wait_to(25);
    check("i1j5_a", bus.rd_addr_a, 20);
    check("i1j5_b", bus.rd_addr_b, 22);
    check("i1j5_tw", bus.tw_addr, 0);
    wait_to(30);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_to(44);
    check("i2j5_stage", bus.stage, 2);
    check("i2j5_a", bus.rd_addr_a, 9);
    check("i2j5_b", bus.rd_addr_b, 13);
    check("i2j5_tw", bus.tw_addr, 4);
    wait_to(92);
    check("i4j15_a", bus.rd_addr_a, 15);
    check("i4j15_b", bus.rd_addr_b, 31);
    check("i4j15_tw", bus.tw_addr, 15);
`ifdef FFT_CTRL_UNLOAD_EN
    wait_to(96);
    check("unl_k0", bus.out_addr, 0);
    wait_to(97);
    check("unl_k1", bus.out_addr, 16);
    wait_to(99);
    check("unl_k3", bus.out_addr, 24);
    check("unl_busy", bus.busy, 1);
`else
    wait_to(96);
    check("c96_done", bus.done, 1);
    check("c96_busy", bus.busy, 0);
`endif
    wait_done("r1", DONE_CYC);
    check("r1_first_rd", first_rd, 1);
    check("r1_first_wr", first_wr, 4);

    // Run 2: five stalled cycles in the middle of stage 2.
    step();
    run_start();
    wait_to(45);
    bus.stall = 1'b1;
    #1;
    check("stall_rd_en", bus.rd_en, 0);
    check("stall_stage", bus.stage, 2);
    wait_to(50);
    bus.stall = 1'b0;
    #1;
    check("resume_rd_en", bus.rd_en, 1);
    check("resume_a", bus.rd_addr_a, rot5({4'd6, 1'b0}, 2));
    wait_done("r2", DONE_CYC + 5);

    // Run 3: reset during stage 3 flush, then a clean transform.
    step();
    run_start();
    wait_to(75);
    check("pre_rst_state", bus.fsm_state, S_FLUSH);
    check("pre_rst_stage", bus.stage, 3);
    check("pre_rst_wr_en", bus.wr_en, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_wr_addr_a", bus.wr_addr_a, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_stage", bus.stage, 0);
    check("mid_rst_state", bus.fsm_state, S_IDLE);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_start();
    wait_done("r4", DONE_CYC);
    check("r4_first_wr", first_wr, 4);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
